// File: rtl/vaelix_sequence_gate.sv
// Multi-byte key gate: constant-time key compare, failed-attempt lockout,
// and a complement-shadowed state register that latches a sticky panic on corruption.
module vaelix_sequence_gate #(
    parameter int unsigned             KEY_LEN        = 4,
    parameter logic [KEY_LEN*8-1:0]    KEY            = 32'hB63C_A55A,
    parameter int unsigned             MAX_FAILS      = 3,
    parameter int unsigned             LOCKOUT_CYCLES = 1024
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             ena,
    input  logic [7:0]                       key_byte,
    input  logic                             key_valid,
    input  logic                             relock,
    output logic                             unlocked,
    output logic                             lockout,
    output logic                             panic,
    output logic [$clog2(MAX_FAILS+1)-1:0]   fail_count,
    output logic [7:0]                       seg,
    output logic [7:0]                       glow
);

    localparam int unsigned IW = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
    localparam int unsigned TW = $clog2(LOCKOUT_CYCLES + 1);
    localparam int unsigned FW = $clog2(MAX_FAILS + 1);

    typedef enum logic [2:0] {
        StLocked   = 3'b001,
        StUnlocked = 3'b010,
        StLockout  = 3'b100,
        StPanic    = 3'b111
    } state_e;

    state_e          r_state, w_state_d;
    logic [2:0]      r_state_n;
    logic [IW-1:0]   r_idx, w_idx_d;
    logic            r_miss, w_miss_d;
    logic [TW-1:0]   r_timer, w_timer_d;
    logic [FW-1:0]   r_fail_count, w_fail_d;

    logic [7:0]      w_key_bytes [KEY_LEN];
    logic            w_fault;
    logic            w_last;
    logic            w_any_miss;
    logic [FW-1:0]   w_fail_inc;

    for (genvar i = 0; i < KEY_LEN; i++) begin : g_key_bytes
        assign w_key_bytes[i] = KEY[(KEY_LEN-1-i)*8 +: 8];
    end

    assign w_fault = (r_state != ~r_state_n)
                   || !(r_state inside {StLocked, StUnlocked, StLockout, StPanic})
                   || (r_fail_count > FW'(MAX_FAILS))
                   || (r_timer > TW'(LOCKOUT_CYCLES));

    assign w_last     = (r_idx == IW'(KEY_LEN - 1));
    assign w_any_miss = r_miss || (key_byte != w_key_bytes[r_idx]);
    assign w_fail_inc = r_fail_count + FW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StLocked;
            r_state_n    <= ~StLocked;
            r_idx        <= '0;
            r_miss       <= 1'b0;
            r_timer      <= '0;
            r_fail_count <= '0;
        end else begin
            r_state      <= w_state_d;
            r_state_n    <= ~w_state_d;
            r_idx        <= w_idx_d;
            r_miss       <= w_miss_d;
            r_timer      <= w_timer_d;
            r_fail_count <= w_fail_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_idx_d   = r_idx;
        w_miss_d  = r_miss;
        w_timer_d = r_timer;
        w_fail_d  = r_fail_count;
        if (w_fault) begin
            w_state_d = StPanic;
        end else begin
            case (r_state)
                StLocked: begin
                    if (ena && relock) begin
                        w_idx_d  = '0;
                        w_miss_d = 1'b0;
                    end else if (ena && key_valid) begin
                        // Every byte is consumed; the verdict only appears after the last one.
                        if (!w_last) begin
                            w_idx_d  = r_idx + IW'(1);
                            w_miss_d = w_any_miss;
                        end else begin
                            w_idx_d  = '0;
                            w_miss_d = 1'b0;
                            if (!w_any_miss) begin
                                w_state_d = StUnlocked;
                                w_fail_d  = '0;
                            end else begin
                                w_fail_d = w_fail_inc;
                                if (w_fail_inc == FW'(MAX_FAILS)) begin
                                    w_state_d = StLockout;
                                    w_timer_d = TW'(LOCKOUT_CYCLES);
                                end
                            end
                        end
                    end
                end
                StUnlocked: begin
                    if (ena && relock) w_state_d = StLocked;
                end
                StLockout: begin
                    w_timer_d = r_timer - TW'(1);
                    if (r_timer == TW'(1)) begin
                        w_state_d = StLocked;
                        w_fail_d  = '0;
                    end
                end
                StPanic: ;
                default: w_state_d = StPanic;
            endcase
        end
    end

    always_comb begin
        unlocked   = (r_state == StUnlocked) && ena;
        lockout    = (r_state == StLockout);
        panic      = (r_state == StPanic);
        fail_count = r_fail_count;
        glow       = unlocked ? 8'hFF : 8'h00;
        seg        = 8'h8C;
        if (panic) begin
            seg = 8'h8C;
        end else if (!ena) begin
            seg = 8'hFF;
        end else begin
            case (r_state)
                StLocked:   seg = 8'hC7;
                StUnlocked: seg = 8'hC1;
                StLockout:  seg = 8'hBF;
                default:    seg = 8'h8C;
            endcase
        end
    end

endmodule

// File: tb/tb_vaelix_sequence_gate.sv
// Bench for vaelix_sequence_gate: vector table, directed lockout/panic/reset
// sequences, and randomized traffic against an attempt-level reference model.
module tb_vaelix_sequence_gate;

    localparam int unsigned KL = 4;
    localparam int unsigned MF = 3;
    localparam int unsigned LC = 16;
    localparam logic [31:0] GOOD = 32'hB63CA55A;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] key_byte;
    logic       key_valid;
    logic       relock;
    logic       unlocked;
    logic       lockout;
    logic       panic;
    logic [1:0] fail_count;
    logic [7:0] seg;
    logic [7:0] glow;

    vaelix_sequence_gate #(
        .KEY_LEN        (KL),
        .KEY            (GOOD),
        .MAX_FAILS      (MF),
        .LOCKOUT_CYCLES (LC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .key_byte   (key_byte),
        .key_valid  (key_valid),
        .relock     (relock),
        .unlocked   (unlocked),
        .lockout    (lockout),
        .panic      (panic),
        .fail_count (fail_count),
        .seg        (seg),
        .glow       (glow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    endtask

    function automatic logic [31:0] outs();
        return {11'b0, unlocked, lockout, panic, fail_count, seg, glow};
    endfunction

    function automatic logic [31:0] pack(input bit u, input bit lo, input bit p, input int fc,
                                         input logic [7:0] s);
        logic [1:0] f;
        f = fc[1:0];
        return {11'b0, u, lo, p, f, s, (u ? 8'hFF : 8'h00)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit e, input bit kv, input logic [7:0] kb, input bit rl);
        ena = e; key_valid = kv; key_byte = kb; relock = rl;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1, 0, 8'h00, 0);
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic attempt(input logic [31:0] k);
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, k[31-8*i -: 8], 0);
            tick();
        end
        drive(1, 0, 8'h00, 0);
    endtask

    // Reference model: buffers whole attempts and judges them at once.
    logic [7:0] key_arr [4] = '{8'hB6, 8'h3C, 8'hA5, 8'h5A};
    logic [7:0] m_buf [$];
    bit         m_unl, m_panic;
    int         m_lock, m_fails;

    task automatic model_reset();
        m_buf.delete(); m_unl = 0; m_panic = 0; m_lock = 0; m_fails = 0;
    endtask

    task automatic model_step(input bit e, input bit kv, input logic [7:0] kb, input bit rl);
        bit ok;
        if (m_panic) return;
        if (m_lock > 0) begin
            m_lock--;
            if (m_lock == 0) m_fails = 0;
        end else if (m_unl) begin
            if (e && rl) m_unl = 0;
        end else if (e) begin
            if (rl) m_buf.delete();
            else if (kv) begin
                m_buf.push_back(kb);
                if (m_buf.size() == KL) begin
                    ok = 1;
                    for (int i = 0; i < KL; i++) if (m_buf[i] != key_arr[i]) ok = 0;
                    m_buf.delete();
                    if (ok) begin
                        m_unl = 1; m_fails = 0;
                    end else begin
                        m_fails++;
                        if (m_fails == MF) m_lock = LC;
                    end
                end
            end
        end
    endtask

    function automatic logic [31:0] model_outs(input bit e);
        logic [7:0] s;
        if (m_panic) s = 8'h8C;
        else if (!e) s = 8'hFF;
        else if (m_lock > 0) s = 8'hBF;
        else if (m_unl) s = 8'hC1;
        else s = 8'hC7;
        return pack(m_unl && e && !m_panic && m_lock == 0, m_lock > 0, m_panic, m_fails, s);
    endfunction

    typedef struct {
        bit         e;
        bit         kv;
        logic [7:0] kb;
        bit         rl;
        bit         u;
        int         fc;
        logic [7:0] s;
    } vec_t;

    vec_t vt [28];

    function automatic vec_t mk(input bit e, input bit kv, input logic [7:0] kb, input bit rl,
                                input bit u, input int fc, input logic [7:0] s);
        vec_t v;
        v.e = e; v.kv = kv; v.kb = kb; v.rl = rl; v.u = u; v.fc = fc; v.s = s;
        return v;
    endfunction

    initial begin
        int cnt;
        logic [31:0] rv;
        bit re, rkv, rrl;
        logic [7:0] rkb;

        vt[0]  = mk(1, 1, 8'hB6, 0, 0, 0, 8'hC7);
        vt[1]  = mk(1, 1, 8'h3C, 0, 0, 0, 8'hC7);
        vt[2]  = mk(1, 1, 8'hA5, 0, 0, 0, 8'hC7);
        vt[3]  = mk(1, 1, 8'h5A, 0, 1, 0, 8'hC1);
        vt[4]  = mk(1, 0, 8'h00, 1, 0, 0, 8'hC7);
        vt[5]  = mk(1, 1, 8'h00, 0, 0, 0, 8'hC7);
        vt[6]  = mk(1, 1, 8'h3C, 0, 0, 0, 8'hC7);
        vt[7]  = mk(1, 1, 8'hA5, 0, 0, 0, 8'hC7);
        vt[8]  = mk(1, 1, 8'h5A, 0, 0, 1, 8'hC7);
        vt[9]  = mk(1, 1, 8'hB6, 0, 0, 1, 8'hC7);
        vt[10] = mk(1, 1, 8'h3C, 0, 0, 1, 8'hC7);
        vt[11] = mk(1, 1, 8'hA5, 1, 0, 1, 8'hC7);
        vt[12] = mk(1, 1, 8'hB6, 0, 0, 1, 8'hC7);
        vt[13] = mk(1, 1, 8'h3C, 0, 0, 1, 8'hC7);
        vt[14] = mk(1, 1, 8'hA5, 0, 0, 1, 8'hC7);
        vt[15] = mk(1, 1, 8'h5A, 0, 1, 0, 8'hC1);
        vt[16] = mk(1, 1, 8'h00, 0, 1, 0, 8'hC1);
        vt[17] = mk(0, 0, 8'h00, 0, 0, 0, 8'hFF);
        vt[18] = mk(0, 0, 8'h00, 1, 0, 0, 8'hFF);
        vt[19] = mk(1, 0, 8'h00, 0, 1, 0, 8'hC1);
        vt[20] = mk(1, 0, 8'h00, 1, 0, 0, 8'hC7);
        vt[21] = mk(1, 1, 8'hB6, 0, 0, 0, 8'hC7);
        vt[22] = mk(1, 1, 8'h3C, 0, 0, 0, 8'hC7);
        vt[23] = mk(0, 1, 8'hA5, 0, 0, 0, 8'hFF);
        vt[24] = mk(0, 1, 8'h00, 0, 0, 0, 8'hFF);
        vt[25] = mk(1, 1, 8'hA5, 0, 0, 0, 8'hC7);
        vt[26] = mk(1, 1, 8'h5A, 0, 1, 0, 8'hC1);
        vt[27] = mk(1, 0, 8'h00, 1, 0, 0, 8'hC7);

        // Reset values, with ena low then high.
        rst_n = 1'b0;
        drive(0, 0, 8'h00, 0);
        #3;
        chk("reset_ena_low", outs(), pack(0, 0, 0, 0, 8'hFF));
        do_reset();
        chk("reset_ena_high", outs(), pack(0, 0, 0, 0, 8'hC7));

        for (int i = 0; i < 28; i++) begin
            drive(vt[i].e, vt[i].kv, vt[i].kb, vt[i].rl);
            tick();
            chk($sformatf("vec%0d", i), outs(), pack(vt[i].u, 0, 0, vt[i].fc, vt[i].s));
        end

        // Lockout: duration, ignored key during lockout, recovery.
        do_reset();
        repeat (3) attempt(32'h0000_0000);
        chk("lockout_enter", outs(), pack(0, 1, 0, 3, 8'hBF));
        cnt = 1;
        for (int k = 0; k < 40; k++) begin
            if (k < 4) drive(1, 1, key_arr[k], 0);
            else drive(1, 0, 8'h00, 0);
            tick();
            if (lockout) cnt++;
            else break;
        end
        chk("lockout_cycles", 32'(cnt), 32'(LC));
        chk("lockout_exit", outs(), pack(0, 0, 0, 0, 8'hC7));
        attempt(GOOD);
        chk("unlock_after_lockout", outs(), pack(1, 0, 0, 0, 8'hC1));

        // Success clears the failure count.
        do_reset();
        repeat (2) attempt(32'hB63C_A55B);
        chk("two_fails", outs(), pack(0, 0, 0, 2, 8'hC7));
        attempt(GOOD);
        chk("fails_cleared", outs(), pack(1, 0, 0, 0, 8'hC1));
        drive(1, 0, 8'h00, 1);
        tick();
        repeat (2) attempt(32'h1111_1111);
        chk("no_lockout", outs(), pack(0, 0, 0, 2, 8'hC7));

        // Reset in the middle of lockout acts immediately.
        do_reset();
        repeat (3) attempt(32'hFFFF_FFFF);
        repeat (5) tick();
        chk("mid_lockout", outs(), pack(0, 1, 0, 3, 8'hBF));
        rst_n = 1'b0;
        #1;
        chk("async_reset", outs(), pack(0, 0, 0, 0, 8'hC7));
        tick();
        rst_n = 1'b1;

        // Shadow corruption forces a sticky panic.
        do_reset();
        force dut.r_state_n = 3'b001;
        tick();
        chk("panic_enter", outs(), pack(0, 0, 1, 0, 8'h8C));
        release dut.r_state_n;
        attempt(GOOD);
        chk("panic_key", outs(), pack(0, 0, 1, 0, 8'h8C));
        drive(0, 0, 8'h00, 1);
        tick();
        chk("panic_ena_low", outs(), pack(0, 0, 1, 0, 8'h8C));
        drive(1, 0, 8'h00, 0);
        tick();
        chk("panic_ena_high", outs(), pack(0, 0, 1, 0, 8'h8C));
        rst_n = 1'b0;
        #1;
        chk("panic_cleared", outs(), pack(0, 0, 0, 0, 8'hC7));
        tick();
        rst_n = 1'b1;

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        for (int c = 0; c < 800; c++) begin
            re  = ($urandom_range(0, 99) < 92);
            rkv = ($urandom_range(0, 99) < 70);
            rrl = ($urandom_range(0, 99) < 5);
            rv  = $urandom();
            rkb = ($urandom_range(0, 99) < 65) ? key_arr[m_buf.size() % 4] : rv[7:0];
            drive(re, rkv, rkb, rrl);
            model_step(re, rkv, rkb, rrl);
            tick();
            chk($sformatf("rand%0d", c), outs(), model_outs(re));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
